// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing source: pixel/line counters, sync pulses, display enable,
// line/frame strobes and a frame counter, with sync/enable/strobes delayable 0..3 clocks.
module vga_timing_gen #(
  parameter int H_DISPLAY  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_DISPLAY  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic       line_start,
  output logic       frame_start,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024) || (SYNC_DELAY < 0) || (SYNC_DELAY > 3)) begin : g_param_err
      $error("vga_timing_gen: totals must be <= 1024 and SYNC_DELAY within 0..3");
    end
  endgenerate

  // Frame counter advances on the same edge the position wraps back to (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos        <= '0;
      vpos        <= '0;
      frame_count <= '0;
    end else if (hpos == H_LAST) begin
      hpos <= '0;
      if (vpos == V_LAST) begin
        vpos        <= '0;
        frame_count <= frame_count + 8'd1;
      end else begin
        vpos <= vpos + 10'd1;
      end
    end else begin
      hpos <= hpos + 10'd1;
    end
  end

  // Internal decode is active-high; {hsync, vsync, display_on, line_start, frame_start, frame_end}.
  logic [5:0] raw;
  logic [5:0] dly_out;

  assign raw[5] = (hpos >= HS_START) && (hpos < HS_END);
  assign raw[4] = (vpos >= VS_START) && (vpos < VS_END);
  assign raw[3] = (hpos < H_VIS) && (vpos < V_VIS);
  assign raw[2] = (hpos == 10'd0);
  assign raw[1] = (hpos == 10'd0) && (vpos == 10'd0);
  assign raw[0] = (hpos == 10'd0) && (vpos == V_VIS);

  generate
    if (SYNC_DELAY == 0) begin : g_nodelay
      assign dly_out = raw;
    end else begin : g_delay
      logic [5:0] pipe [SYNC_DELAY];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < SYNC_DELAY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= raw;
          for (int i = 1; i < SYNC_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign dly_out = pipe[SYNC_DELAY-1];
    end
  endgenerate

  // Cleared pipeline stages read as inactive, so polarity is applied only here.
  assign hsync       = dly_out[5] ? HSYNC_POL : ~HSYNC_POL;
  assign vsync       = dly_out[4] ? VSYNC_POL : ~VSYNC_POL;
  assign display_on  = dly_out[3];
  assign line_start  = dly_out[2];
  assign frame_start = dly_out[1];
  assign frame_end   = dly_out[0];

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Upstream timing source for the VGA pixel generators: produces 640x480@60 Hz (25.175 MHz pixel clock) horizontal/vertical counters, sync pulses, display enable and per-line/per-frame strobes.
- `frame_end` and `frame_count` give pixel generators a clock-domain-safe animation tick, so no logic needs to be clocked from `vsync`.
- A configurable delay aligns sync/enable with pixel logic that registers its shape decode.

## Interface
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, 1 = hsync active high, 0 = active low
- VSYNC_POL, 0, 1 = vsync active high, 0 = active low
- SYNC_DELAY, 1, register stages (0..3) applied to hsync/vsync/display_on/strobes relative to hpos/vpos

Ports:
- clk  in  1  pixel clock, single clock domain
- reset  in  1  asynchronous, active-high reset
- hpos  out  10  horizontal counter, 0..H_TOTAL-1
- vpos  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- display_on  out  1  high in visible area
- line_start  out  1  one-clock pulse at hpos==0
- frame_start  out  1  one-clock pulse at hpos==0, vpos==0
- frame_end  out  1  one-clock pulse at hpos==0, vpos==V_DISPLAY (start of vblank)
- frame_count  out  8  frames completed since reset, wraps 255->0

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525). Elaboration error if either exceeds 1024 or SYNC_DELAY > 3.
- hpos increments every clock; at H_TOTAL-1 it wraps to 0 and vpos increments. vpos wraps to 0 after V_TOTAL-1 on the same clock hpos wraps.
- frame_count increments on the clock where (hpos,vpos) goes (H_TOTAL-1,V_TOTAL-1) -> (0,0); 8-bit unsigned wrap.
- Raw decode from current hpos/vpos:
  - hsync active for H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync active for V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), the whole line regardless of hpos.
  - display_on = hpos<H_DISPLAY && vpos<V_DISPLAY.
  - Strobes are as listed under ports.
- Raw decode passes through a SYNC_DELAY-deep shift pipeline. Delay 0 is purely combinational from the counter registers.
- Output polarity is applied at the pipeline output. The inactive level is ~POL.

## Timing
- Reset (async assert, any time incl. mid-frame): hpos=0, vpos=0, frame_count=0.
  - Pipeline stages clear to inactive: hsync/vsync at idle level, display_on=0, all strobes 0.
  - With SYNC_DELAY=0, outputs follow the raw decode of (0,0) while in reset: display_on=1, line_start=1, frame_start=1.
- First clock edge after reset deassertion: hpos=1.
  - With SYNC_DELAY=N>=1, the stream for (0,0) (display_on=1, line_start, frame_start) appears N clocks after deassertion. The delayed stream for counter position P appears when hpos is P+N.
- frame_count is not delayed; it changes on the same edge hpos/vpos return to (0,0).
- Strobes are exactly one clock wide. frame_start and line_start coincide on the first clock of each frame. frame_end never coincides with frame_start.
- Counter wrap and frame_count increment happen on the same edge. No glitch or skipped value on any output.

## Test plan
- Reset, SYNC_DELAY=1: assert reset -> hpos=0, vpos=0, frame_count=0, hsync=1, vsync=1, display_on=0, strobes 0; release -> display_on=1 and frame_start=1 exactly one clock later, for one clock.
- Horizontal timing, defaults: over one line -> hsync low exactly at delayed hpos 656..751 (96 clocks); display_on high for 640 clocks; line period 800 clocks; line_start one pulse per line.
- Frame wrap: run to hpos=799, vpos=524 -> next edge hpos=0, vpos=0, frame_count +1; vsync low for 2 lines (1600 clocks) at vpos 490..491; frame_end at vpos=480, hpos=0 (delayed).
- frame_count wrap: run 256 frames -> frame_count 255->0; frame_start count equals 256.
- SYNC_DELAY=0 and 3, HSYNC_POL=1: hsync goes high at hpos=656 (delay 0) or when hpos=659 (delay 3); display_on falls at hpos 640 / 643.
- Mid-frame reset at hpos=300, vpos=200 -> immediate return to reset values, frame_count=0; after release the full frame sequence restarts from (0,0).
